load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have parameter ERR_ON_MISALIGN, default 1: 1 = misaligned access returns error; 0 = low address bits ignored and access forced aligned.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port req_valid, input, 1 bit: request present.
REQ-005 The module SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-006 The module SHALL have port req_op, input, 3 bits: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
REQ-007 The module SHALL have port req_addr, input, 32 bits: byte address.
REQ-008 The module SHALL have port req_wdata, input, 32 bits: store data, right-justified.
REQ-009 The module SHALL have port resp_valid, output, 1 bit: response present.
REQ-010 The module SHALL have port resp_ready, input, 1 bit: consumer takes response.
REQ-011 The module SHALL have port resp_rdata, output, 32 bits: extended load result; 0 for stores and errors.
REQ-012 The module SHALL have port resp_error, output, 1 bit: misaligned access.
REQ-013 The module SHALL have port mem_addr, output, 32 bits: word address to Memory A, {addr[31:2],2'b00}.
REQ-014 The module SHALL have port mem_rdata, input, 32 bits: Memory D, combinational read of mem_addr.
REQ-015 The module SHALL have port mem_we, output, 1 bit: Memory WE; write on rising edge.
REQ-016 The module SHALL have port mem_wdata, output, 32 bits: Memory WD.

Function
REQ-017 The unit SHALL implement states IDLE, READ, WRITE and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge with req_valid=1 in IDLE, and op, addr and wdata SHALL be registered at that edge.
REQ-019 Misalignment SHALL be defined as LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0; LB/LBU/SB are never misaligned.
REQ-020 Transitions out of IDLE on accept: misaligned with ERR_ON_MISALIGN=1 -> RESP with error=1 and no memory access; SW -> WRITE; all other ops -> READ.
REQ-021 Transitions out of READ: loads -> RESP, capturing the extracted result; SH/SB -> WRITE, capturing the merged word.
REQ-022 Transitions out of WRITE: -> RESP.
REQ-023 Transitions out of RESP: when resp_ready=1 -> IDLE; otherwise the state SHALL hold with resp_rdata and resp_error stable.
REQ-024 Byte lanes SHALL be little-endian: byte k = bits [8k+7:8k], selected by addr[1:0]; halfword h = bits [16h+15:16h], selected by addr[1].
REQ-025 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to 32 bits.
REQ-026 SH/SB SHALL perform read-modify-write: replace only the addressed lane in mem_rdata with req_wdata[7:0] or [15:0].
REQ-027 mem_addr SHALL be valid in READ and WRITE and 0 otherwise; mem_wdata SHALL be 0 outside WRITE.
REQ-028 mem_we SHALL equal (state==WRITE) & ~reset.
REQ-029 Latency from the accept edge to resp_valid SHALL be: error 1 cycle; LW/LH/LHU/LB/LBU/SW 2 cycles; SH/SB 3 cycles.
REQ-030 Exactly one memory write SHALL occur per store; a stalled RESP SHALL issue no further memory activity.
REQ-031 With ERR_ON_MISALIGN=0, resp_error SHALL be constantly 0; LW/SW SHALL use addr[1:0]=0 and halfword ops SHALL use addr[0]=0.

Reset
REQ-032 While reset=1 at an edge, state SHALL go to IDLE and resp_rdata and resp_error SHALL clear to 0.
REQ-033 After reset, req_ready SHALL be 1 and resp_valid=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-034 Reset asserted during WRITE SHALL suppress the write; reset in any state SHALL abandon the in-flight request with no response.

Verification
REQ-035 Memory word 0x10 = 0x8899AABB; LB addr 0x11 -> resp_rdata 0xFFFFFFAA, resp_valid 2 cycles after accept; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899.
REQ-036 SB addr 0x13 wdata 0x55, then LW 0x10 -> 0x5599AABB; SH 0x10 wdata 0x1234 -> word 0x5599 1234; exactly one mem_we pulse per store.
REQ-037 LW addr 0x02 with ERR_ON_MISALIGN=1 -> resp_error=1, resp_rdata=0 one cycle after accept, mem_we never asserted; with ERR_ON_MISALIGN=0 -> word at 0x00, error 0.
REQ-038 Hold resp_ready=0 for 5 cycles after an LW -> resp_valid and data stable, req_ready=0, mem_we=0; release -> IDLE next cycle.
REQ-039 Assert reset in the WRITE cycle of SB to 0x20 -> memory word 0x20 unchanged, no resp_valid, req_ready=1 after reset.
REQ-040 Back-to-back SW 0x0..0xFC with data 5*i, then LW each -> all 64 readbacks match, with no lost or duplicated responses.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit with a word-wide memory
//               port. Sub-word stores use read-modify-write. Misaligned
//               accesses either return an error or are forced aligned,
//               selected by ERR_ON_MISALIGN.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ERR_ON_MISALIGN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  localparam logic [2:0] c_OP_LW  = 3'd0;
  localparam logic [2:0] c_OP_LH  = 3'd1;
  localparam logic [2:0] c_OP_LHU = 3'd2;
  localparam logic [2:0] c_OP_LB  = 3'd3;
  localparam logic [2:0] c_OP_LBU = 3'd4;
  localparam logic [2:0] c_OP_SW  = 3'd5;
  localparam logic [2:0] c_OP_SH  = 3'd6;
  localparam logic [2:0] c_OP_SB  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [31:0] r_addr;        // effective (possibly force-aligned) address
  logic [15:0] r_wdata;       // only the low half is ever merged into memory
  logic [31:0] r_mem_wdata;
  logic [31:0] r_resp_rdata;
  logic        r_resp_error;

  logic        w_misalign;
  logic        w_err_accept;
  logic [31:0] w_addr_eff;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  // Classify the incoming request's alignment against its access size
  always_comb begin
    w_misalign = 1'b0;
    case (req_op)
      c_OP_LW, c_OP_SW:           w_misalign = (req_addr[1:0] != 2'b00);
      c_OP_LH, c_OP_LHU, c_OP_SH: w_misalign = req_addr[0];
      default:                    w_misalign = 1'b0;
    endcase
  end

  assign w_err_accept = w_misalign && (ERR_ON_MISALIGN != 0);

  // When errors are disabled, drop the low address bits below the access size
  always_comb begin
    w_addr_eff = req_addr;
    if (ERR_ON_MISALIGN == 0) begin
      case (req_op)
        c_OP_LW, c_OP_SW:           w_addr_eff[1:0] = 2'b00;
        c_OP_LH, c_OP_LHU, c_OP_SH: w_addr_eff[0]   = 1'b0;
        default:                    w_addr_eff      = req_addr;
      endcase
    end
  end

  // Select the addressed little-endian byte and halfword lanes
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Extend the selected lane to the full load result
  always_comb begin
    w_load = 32'd0;
    case (r_op)
      c_OP_LW:  w_load = mem_rdata;
      c_OP_LH:  w_load = {{16{w_half[15]}}, w_half};
      c_OP_LHU: w_load = {16'd0, w_half};
      c_OP_LB:  w_load = {{24{w_byte[7]}}, w_byte};
      c_OP_LBU: w_load = {24'd0, w_byte};
      default:  w_load = 32'd0;
    endcase
  end

  // Merge sub-word store data into the word just read from memory
  always_comb begin
    w_merge = mem_rdata;
    if (r_op == c_OP_SH) begin
      if (r_addr[1]) w_merge[31:16] = r_wdata;
      else           w_merge[15:0]  = r_wdata;
    end else if (r_op == c_OP_SB) begin
      case (r_addr[1:0])
        2'd0: w_merge[7:0]   = r_wdata[7:0];
        2'd1: w_merge[15:8]  = r_wdata[7:0];
        2'd2: w_merge[23:16] = r_wdata[7:0];
        2'd3: w_merge[31:24] = r_wdata[7:0];
        default: w_merge = mem_rdata;
      endcase
    end
  end

  // Control FSM with registered request context and response
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op         <= c_OP_LW;
      r_addr       <= 32'd0;
      r_wdata      <= 16'd0;
      r_mem_wdata  <= 32'd0;
      r_resp_rdata <= 32'd0;
      r_resp_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_addr  <= w_addr_eff;
            r_wdata <= req_wdata[15:0];
            if (w_err_accept) begin
              r_resp_rdata <= 32'd0;
              r_resp_error <= 1'b1;
              r_state      <= S_RESP;
            end else if (req_op == c_OP_SW) begin
              r_mem_wdata <= req_wdata;
              r_state     <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (r_op == c_OP_SH || r_op == c_OP_SB) begin
            r_mem_wdata <= w_merge;
            r_state     <= S_WRITE;
          end else begin
            r_resp_rdata <= w_load;
            r_resp_error <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_WRITE: begin
          r_resp_rdata <= 32'd0;
          r_resp_error <= 1'b0;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_error = r_resp_error;
  assign mem_addr   = (r_state == S_READ || r_state == S_WRITE) ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_we     = (r_state == S_WRITE) & ~reset;
  assign mem_wdata  = (r_state == S_WRITE) ? r_mem_wdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit. Two
//               instances share request fields: one with misalignment errors
//               enabled, one with forced alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_valid0;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_ready;

  logic        req_ready, resp_valid, resp_error, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_rdata, mem_wdata;
  logic        req_ready0, resp_valid0, resp_error0, mem_we0;
  logic [31:0] resp_rdata0, mem_addr0, mem_rdata0, mem_wdata0;

  logic [31:0] mem1 [0:63];
  logic [31:0] mem0 [0:63];
  int we_cnt = 0, we_cnt0 = 0, hs_cnt = 0;
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  load_store_unit #(.ERR_ON_MISALIGN(1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  load_store_unit #(.ERR_ON_MISALIGN(0)) dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_rdata(resp_rdata0),
    .resp_error(resp_error0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0),
    .mem_we(mem_we0), .mem_wdata(mem_wdata0)
  );

  assign mem_rdata  = mem1[mem_addr[7:2]];
  assign mem_rdata0 = mem0[mem_addr0[7:2]];

  // Behavioural word memories with write counters
  always @(posedge clock) begin
    if (mem_we) begin
      mem1[mem_addr[7:2]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (mem_we0) begin
      mem0[mem_addr0[7:2]] <= mem_wdata0;
      we_cnt0 <= we_cnt0 + 1;
    end
    if (resp_valid && resp_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request to the selected instance and take its response
  task automatic do_req(input bit sel, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    logic v;
    req_op = op; req_addr = addr; req_wdata = wd;
    if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0; req_valid0 = 1'b0;
    lat = 1;
    v = sel ? resp_valid0 : resp_valid;
    while (!v && lat < 10) begin
      @(posedge clock); #1;
      lat++;
      v = sel ? resp_valid0 : resp_valid;
    end
    rd = sel ? resp_rdata0 : resp_rdata;
    er = sel ? resp_error0 : resp_error;
    if (!v) chk("resp_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clock); #1;
    end
  endtask

  logic [31:0] rd, hold;
  logic        er;
  int          lat, w0, h0;

  initial begin
    for (int i = 0; i < 64; i++) begin mem1[i] = 32'd0; mem0[i] = 32'd0; end
    mem1[0] = 32'h7F000000;
    mem1[4] = 32'h8899AABB;
    mem1[8] = 32'h01020304;
    mem0[0] = 32'hCAFEF00D;
    reset = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0; resp_ready = 1'b1;
    req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_dut0_addr", mem_addr0, 32'd0);

    // Loads with sign/zero extension
    do_req(0, 3'd3, 32'h11, 0, rd, er, lat);
    chk("lb_11", rd, 32'hFFFFFFAA); chk("lb_11_lat", lat, 2); chk("lb_11_err", {31'd0, er}, 0);
    do_req(0, 3'd4, 32'h11, 0, rd, er, lat);  chk("lbu_11", rd, 32'h000000AA);
    do_req(0, 3'd1, 32'h12, 0, rd, er, lat);  chk("lh_12", rd, 32'hFFFF8899); chk("lh_12_lat", lat, 2);
    do_req(0, 3'd2, 32'h12, 0, rd, er, lat);  chk("lhu_12", rd, 32'h00008899);
    do_req(0, 3'd3, 32'h10, 0, rd, er, lat);  chk("lb_10", rd, 32'hFFFFFFBB);
    do_req(0, 3'd4, 32'h13, 0, rd, er, lat);  chk("lbu_13", rd, 32'h00000088);
    do_req(0, 3'd2, 32'h10, 0, rd, er, lat);  chk("lhu_10", rd, 32'h0000AABB);
    do_req(0, 3'd3, 32'h03, 0, rd, er, lat);  chk("lb_03", rd, 32'h0000007F); chk("lb_03_err", {31'd0, er}, 0);

    // Sub-word stores via read-modify-write
    w0 = we_cnt;
    do_req(0, 3'd7, 32'h13, 32'h55, rd, er, lat);
    chk("sb_lat", lat, 3); chk("sb_rdata", rd, 0); chk("sb_we_cnt", we_cnt - w0, 1);
    chk("sb_mem", mem1[4], 32'h5599AABB);
    do_req(0, 3'd0, 32'h10, 0, rd, er, lat);  chk("lw_10", rd, 32'h5599AABB);
    w0 = we_cnt;
    do_req(0, 3'd6, 32'h10, 32'hFFFF1234, rd, er, lat);
    chk("sh_lat", lat, 3); chk("sh_we_cnt", we_cnt - w0, 1); chk("sh_mem", mem1[4], 32'h55991234);
    do_req(0, 3'd6, 32'h12, 32'h00007E00, rd, er, lat);  chk("sh_hi_mem", mem1[4], 32'h7E001234);
    w0 = we_cnt;
    do_req(0, 3'd5, 32'h14, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", lat, 2); chk("sw_we_cnt", we_cnt - w0, 1); chk("sw_mem", mem1[5], 32'hDEADBEEF);

    // Misaligned accesses, error mode
    w0 = we_cnt;
    do_req(0, 3'd0, 32'h02, 0, rd, er, lat);
    chk("mis_lw_err", {31'd0, er}, 1); chk("mis_lw_rd", rd, 0); chk("mis_lw_lat", lat, 1);
    do_req(0, 3'd6, 32'h01, 32'h1111, rd, er, lat);
    chk("mis_sh_err", {31'd0, er}, 1); chk("mis_sh_lat", lat, 1);
    do_req(0, 3'd5, 32'h13, 32'h2222, rd, er, lat);  chk("mis_sw_err", {31'd0, er}, 1);
    chk("mis_no_we", we_cnt - w0, 0); chk("mis_mem0", mem1[0], 32'h7F000000);
    do_req(0, 3'd0, 32'h00, 0, rd, er, lat);  chk("after_err_lw", rd, 32'h7F000000); chk("after_err_err", {31'd0, er}, 0);

    // Misaligned accesses, forced-alignment mode
    do_req(1, 3'd0, 32'h02, 0, rd, er, lat);
    chk("al_lw", rd, 32'hCAFEF00D); chk("al_lw_err", {31'd0, er}, 0); chk("al_lw_lat", lat, 2);
    do_req(1, 3'd1, 32'h03, 0, rd, er, lat);  chk("al_lh", rd, 32'hFFFFCAFE); chk("al_lh_err", {31'd0, er}, 0);
    do_req(1, 3'd4, 32'h03, 0, rd, er, lat);  chk("al_lbu", rd, 32'h000000CA);
    w0 = we_cnt0;
    do_req(1, 3'd5, 32'h03, 32'h11223344, rd, er, lat);
    chk("al_sw_err", {31'd0, er}, 0); chk("al_sw_mem", mem0[0], 32'h11223344); chk("al_sw_we", we_cnt0 - w0, 1);
    do_req(1, 3'd6, 32'h01, 32'h0000ABCD, rd, er, lat);
    chk("al_sh_err", {31'd0, er}, 0); chk("al_sh_mem", mem0[0], 32'h1122ABCD);

    // Stalled response holds steady with no memory activity
    resp_ready = 1'b0;
    req_op = 3'd0; req_addr = 32'h14; req_valid = 1'b1;
    @(posedge clock); #1 req_valid = 1'b0;
    @(posedge clock); #1;
    chk("stall_valid0", {31'd0, resp_valid}, 1);
    hold = resp_rdata;
    chk("stall_data", hold, 32'hDEADBEEF);
    w0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("stall_valid", {31'd0, resp_valid}, 1);
      chk("stall_rdata", resp_rdata, 32'hDEADBEEF);
      chk("stall_ready", {31'd0, req_ready}, 0);
      chk("stall_addr", mem_addr, 0);
    end
    chk("stall_no_we", we_cnt - w0, 0);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    chk("stall_rel_ready", {31'd0, req_ready}, 1);
    chk("stall_rel_valid", {31'd0, resp_valid}, 0);

    // Reset during the write cycle of a byte store
    w0 = we_cnt;
    req_op = 3'd7; req_addr = 32'h20; req_wdata = 32'hEE; req_valid = 1'b1;
    @(posedge clock); #1 req_valid = 1'b0;
    @(posedge clock); #1;
    chk("rstw_pre_we", {31'd0, mem_we}, 1);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    chk("rstw_mem", mem1[8], 32'h01020304);
    chk("rstw_we_cnt", we_cnt - w0, 0);
    chk("rstw_ready", {31'd0, req_ready}, 1);
    @(posedge clock); #1;
    chk("rstw_no_resp", {31'd0, resp_valid}, 0);

    // Back-to-back word stores then readback of the whole memory
    h0 = hs_cnt; w0 = we_cnt;
    for (int i = 0; i < 64; i++) do_req(0, 3'd5, 32'(i * 4), 32'(5 * i), rd, er, lat);
    chk("b2b_we_cnt", we_cnt - w0, 64);
    for (int i = 0; i < 64; i++) begin
      do_req(0, 3'd0, 32'(i * 4), 0, rd, er, lat);
      chk("b2b_rd", rd, 32'(5 * i));
    end
    chk("b2b_hs_cnt", hs_cnt - h0, 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
